// File: rtl/miter_pkg.sv
// Shared types and helpers for the lockstep equivalence miter.
package miter_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CHECK, S_FAIL} state_e;
  typedef enum logic {MODE_EXACT, MODE_MASKED} mode_e;

  localparam int MAX_W  = 64;
  localparam int MAX_CH = 16;
  localparam int BUS_W  = MAX_W * MAX_CH;

  // Extract channel k of a packed bus of w-bit channels; callers truncate to their width.
  function automatic logic [MAX_W-1:0] chan_slice(input logic [BUS_W-1:0] bus,
                                                  input int k, input int w);
    return MAX_W'(bus >> (k * w));
  endfunction

endpackage

// File: rtl/miter_delay_line.sv
// Valid-advanced shift register that aligns the reference stream LAG samples behind.
module miter_delay_line #(
  parameter int LAG = 0,
  parameter int W   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (LAG == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst_n, adv, flush};
      assign q = d;
    end else begin : g_shift
      logic [LAG-1:0][W-1:0] stg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg <= '0;
        end else if (flush) begin
          stg <= '0;
        end else if (adv) begin
          stg[0] <= d;
          for (int i = 1; i < LAG; i++) stg[i] <= stg[i-1];
        end
      end

      assign q = stg[LAG-1];
    end
  endgenerate

endmodule

// File: rtl/lockstep_miter.sv
// Sequential equivalence monitor: compares lag-aligned ref/dut channel pairs and
// captures the first miscompare; err is the single property to prove low.
module lockstep_miter
  import miter_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CHANNELS     = 2,
  parameter int LAG          = 0,
  parameter int CNT_W        = 8,
  parameter int STOP_ON_FAIL = 1,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clear,
  input  logic                      valid,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          mask,
  input  logic [CHANNELS*WIDTH-1:0] ref_o,
  input  logic [CHANNELS*WIDTH-1:0] dut_o,
  output logic                      mismatch,
  output logic                      err,
  output logic [CH_W-1:0]           err_chan,
  output logic [CNT_W-1:0]          err_sample,
  output logic [CNT_W-1:0]          mis_count,
  output logic                      busy
);

  localparam int BW = CHANNELS * WIDTH;
  localparam logic [2:0] FILL_LAST = (LAG == 0) ? 3'd0 : 3'(LAG - 1);

  state_e              state;
  logic [2:0]          fill;
  logic [CNT_W-1:0]    samp;
  logic [BW-1:0]       ref_d;
  logic [WIDTH-1:0]    cmp_mask;
  logic [CHANNELS-1:0] chan_mis;
  logic [CH_W-1:0]     first_ch;
  logic                flush, adv;

  // Any exit toward IDLE discards alignment history so re-arming refills from scratch.
  assign flush = clear | ~en | (state == S_IDLE);
  assign adv   = valid & en & ~clear & ((state == S_ARMED) | (state == S_CHECK));

  miter_delay_line #(.LAG(LAG), .W(BW)) u_dly (
    .clk   (clk),
    .rst_n (rst),
    .adv   (adv),
    .flush (flush),
    .d     (ref_o),
    .q     (ref_d)
  );

  assign cmp_mask = (mode_e'(mode) == MODE_MASKED) ? mask : '0;

  // Walk high-to-low so the last hit recorded is the lowest miscompared channel.
  always_comb begin
    chan_mis = '0;
    first_ch = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      chan_mis[k] = |((WIDTH'(chan_slice(BUS_W'(ref_d), k, WIDTH)) ^
                       WIDTH'(chan_slice(BUS_W'(dut_o), k, WIDTH))) & ~cmp_mask);
      if (chan_mis[k]) first_ch = CH_W'(k);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      fill       <= '0;
      samp       <= '0;
      mismatch   <= 1'b0;
      err        <= 1'b0;
      err_chan   <= '0;
      err_sample <= '0;
      mis_count  <= '0;
    end else if (clear) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      fill       <= '0;
      samp       <= '0;
      mismatch   <= 1'b0;
      err        <= 1'b0;
      err_chan   <= '0;
      err_sample <= '0;
      mis_count  <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        S_IDLE: begin
          fill <= '0;
          if (en) begin
            busy <= 1'b1;
            if (LAG == 0) state <= S_CHECK;
            else          state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (!en) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (valid) begin
            fill <= fill + 3'd1;
            if (fill == FILL_LAST) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!en) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (valid) begin
            if (samp != '1) samp <= samp + 1'b1;
            if (|chan_mis) begin
              mismatch <= 1'b1;
              if (mis_count != '1) mis_count <= mis_count + 1'b1;
              if (!err) begin
                err        <= 1'b1;
                err_chan   <= first_ch;
                err_sample <= samp;
              end
              if (STOP_ON_FAIL != 0) begin
                state <= S_FAIL;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lockstep_miter.sv
// Scoreboarded bench for lockstep_miter: three configurations share one stimulus bus.
module tb_lockstep_miter;

  typedef struct {
    logic       mism;
    logic [7:0] cnt;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, clear = 1'b0, valid = 1'b0, mode = 1'b0;
  logic [7:0]  mask = '0;
  logic [15:0] ref_o = '0, dut_o = '0;

  logic       mis_a, err_a, chan_a, busy_a;
  logic [7:0] samp_a, cnt_a;
  logic       mis_b, err_b, chan_b, busy_b;
  logic [7:0] samp_b, cnt_b;
  logic       mis_c, err_c, chan_c, busy_c;
  logic [3:0] samp_c, cnt_c;

  int checks = 0;
  int errors = 0;
  exp_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;

  lockstep_miter #(.WIDTH(8), .CHANNELS(2), .LAG(0), .CNT_W(8), .STOP_ON_FAIL(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .valid(valid), .mode(mode), .mask(mask),
    .ref_o(ref_o), .dut_o(dut_o), .mismatch(mis_a), .err(err_a), .err_chan(chan_a),
    .err_sample(samp_a), .mis_count(cnt_a), .busy(busy_a));

  lockstep_miter #(.WIDTH(8), .CHANNELS(2), .LAG(2), .CNT_W(8), .STOP_ON_FAIL(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .valid(valid), .mode(mode), .mask(mask),
    .ref_o(ref_o), .dut_o(dut_o), .mismatch(mis_b), .err(err_b), .err_chan(chan_b),
    .err_sample(samp_b), .mis_count(cnt_b), .busy(busy_b));

  lockstep_miter #(.WIDTH(8), .CHANNELS(2), .LAG(0), .CNT_W(4), .STOP_ON_FAIL(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .valid(valid), .mode(mode), .mask(mask),
    .ref_o(ref_o), .dut_o(dut_o), .mismatch(mis_c), .err(err_c), .err_chan(chan_c),
    .err_sample(samp_c), .mis_count(cnt_c), .busy(busy_c));

  task automatic drive(input logic e, input logic c, input logic v,
                       input logic [15:0] r, input logic [15:0] d);
    en = e; clear = c; valid = v; ref_o = r; dut_o = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rst_err_a got %0h exp 0", err_a); end
    checks++; if (mis_a !== 1'b0) begin errors++; $display("FAIL rst_mis_a got %0h exp 0", mis_a); end
    checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL rst_cnt_a got %0h exp 0", cnt_a); end
    checks++; if (samp_a !== 8'd0) begin errors++; $display("FAIL rst_samp_a got %0h exp 0", samp_a); end
    checks++; if (chan_a !== 1'b0) begin errors++; $display("FAIL rst_chan_a got %0h exp 0", chan_a); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL rst_busy_b got %0h exp 0", busy_b); end
    rst = 1'b1;
  endtask

  task automatic test_identical();
    logic [15:0] r;
    exp_t e;
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL ident_busy got %0h exp 1", busy_a); end
    for (int i = 0; i < 20; i++) begin
      r = 16'($urandom);
      qa.push_back('{1'b0, 8'd0});
      drive(1'b1, 1'b0, 1'b1, r, r);
      e = qa.pop_front();
      checks++; if (mis_a !== e.mism) begin errors++; $display("FAIL ident_mis[%0d] got %0h exp %0h", i, mis_a, e.mism); end
      checks++; if (cnt_a !== e.cnt) begin errors++; $display("FAIL ident_cnt[%0d] got %0h exp %0h", i, cnt_a, e.cnt); end
    end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL ident_err got %0h exp 0", err_a); end
  endtask

  task automatic test_lag(input int dl, input logic exp_err);
    logic [15:0] rv [12];
    logic [15:0] d;
    logic        failed, em;
    exp_t        e;
    for (int i = 0; i < 12; i++) rv[i] = 16'(32'h1000 + i * 32'h0111);
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL lag%0d_armed_busy got %0h exp 1", dl, busy_b); end
    failed = 1'b0;
    for (int i = 0; i < 12; i++) begin
      d = (i >= dl) ? rv[i - dl] : 16'h0000;
      if (i >= 2) begin
        em = (dl != 2) && !failed;
        if (em) failed = 1'b1;
        qb.push_back('{em, {7'd0, failed}});
      end
      drive(1'b1, 1'b0, 1'b1, rv[i], d);
      if (i >= 2) begin
        e = qb.pop_front();
        checks++; if (mis_b !== e.mism) begin errors++; $display("FAIL lag%0d_mis[%0d] got %0h exp %0h", dl, i, mis_b, e.mism); end
        checks++; if (cnt_b !== e.cnt) begin errors++; $display("FAIL lag%0d_cnt[%0d] got %0h exp %0h", dl, i, cnt_b, e.cnt); end
      end else begin
        checks++; if (mis_b !== 1'b0) begin errors++; $display("FAIL lag%0d_armed_mis[%0d] got %0h exp 0", dl, i, mis_b); end
      end
      drive(1'b1, 1'b0, 1'b0, rv[i], d);
      drive(1'b1, 1'b0, 1'b0, rv[i], d);
    end
    checks++; if (err_b !== exp_err) begin errors++; $display("FAIL lag%0d_err got %0h exp %0h", dl, err_b, exp_err); end
    checks++; if (samp_b !== 8'd0) begin errors++; $display("FAIL lag%0d_sample got %0h exp 0", dl, samp_b); end
    checks++; if (busy_b !== !exp_err) begin errors++; $display("FAIL lag%0d_busy got %0h exp %0h", dl, busy_b, !exp_err); end
  endtask

  task automatic test_chan_err(input logic m);
    logic [15:0] r, d;
    logic        em;
    exp_t        e;
    mode = m; mask = 8'h08;
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      r = 16'($urandom);
      d = r;
      if (i == 5) d = r ^ 16'h0800;
      if (i > 5 && !m) d = ~r;
      em = !m && (i == 5);
      qa.push_back('{em, (!m && i >= 5) ? 8'd1 : 8'd0});
      drive(1'b1, 1'b0, 1'b1, r, d);
      e = qa.pop_front();
      checks++; if (mis_a !== e.mism) begin errors++; $display("FAIL chan_m%0d_mis[%0d] got %0h exp %0h", m, i, mis_a, e.mism); end
      checks++; if (cnt_a !== e.cnt) begin errors++; $display("FAIL chan_m%0d_cnt[%0d] got %0h exp %0h", m, i, cnt_a, e.cnt); end
    end
    checks++; if (err_a !== !m) begin errors++; $display("FAIL chan_m%0d_err got %0h exp %0h", m, err_a, !m); end
    checks++; if (chan_a !== !m) begin errors++; $display("FAIL chan_m%0d_chan got %0h exp %0h", m, chan_a, !m); end
    checks++; if (samp_a !== (m ? 8'd0 : 8'd5)) begin errors++; $display("FAIL chan_m%0d_sample got %0h exp %0h", m, samp_a, (m ? 8'd0 : 8'd5)); end
    checks++; if (busy_a !== m) begin errors++; $display("FAIL chan_m%0d_busy got %0h exp %0h", m, busy_a, m); end
  endtask

  task automatic test_saturate();
    logic [15:0] r;
    exp_t        e;
    mode = 1'b0;
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 20; k++) begin
      r = 16'($urandom);
      qc.push_back('{1'b1, (k + 1 > 15) ? 8'd15 : 8'(k + 1)});
      drive(1'b1, 1'b0, 1'b1, r, ~r);
      e = qc.pop_front();
      checks++; if (mis_c !== e.mism) begin errors++; $display("FAIL sat_mis[%0d] got %0h exp %0h", k, mis_c, e.mism); end
      checks++; if (cnt_c !== e.cnt[3:0]) begin errors++; $display("FAIL sat_cnt[%0d] got %0h exp %0h", k, cnt_c, e.cnt[3:0]); end
    end
    checks++; if (err_c !== 1'b1) begin errors++; $display("FAIL sat_err got %0h exp 1", err_c); end
    checks++; if (samp_c !== 4'd0) begin errors++; $display("FAIL sat_sample got %0h exp 0", samp_c); end
    checks++; if (chan_c !== 1'b0) begin errors++; $display("FAIL sat_chan got %0h exp 0", chan_c); end
  endtask

  task automatic test_clear_wins();
    mode = 1'b0;
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b1, 16'h1234, 16'h0000);
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL clr_pre_err got %0h exp 1", err_a); end
    drive(1'b1, 1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 1'b1, 16'h5678, 16'h0000);
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL clr_err got %0h exp 0", err_a); end
    checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL clr_cnt got %0h exp 0", cnt_a); end
    checks++; if (mis_a !== 1'b0) begin errors++; $display("FAIL clr_mis got %0h exp 0", mis_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL clr_busy got %0h exp 0", busy_a); end
  endtask

  task automatic test_rst_mid();
    mode = 1'b0;
    drive(1'b0, 1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b1, 16'hA5A5, 16'h5A5A);
    checks++; if (mis_c !== 1'b1) begin errors++; $display("FAIL rstmid_pre_mis got %0h exp 1", mis_c); end
    checks++; if (busy_c !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy got %0h exp 1", busy_c); end
    rst = 1'b0;
    #1;
    checks++; if (err_c !== 1'b0) begin errors++; $display("FAIL rstmid_err got %0h exp 0", err_c); end
    checks++; if (mis_c !== 1'b0) begin errors++; $display("FAIL rstmid_mis got %0h exp 0", mis_c); end
    checks++; if (cnt_c !== 4'd0) begin errors++; $display("FAIL rstmid_cnt got %0h exp 0", cnt_c); end
    checks++; if (busy_c !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0h exp 0", busy_c); end
    #2 rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL rearm_busy got %0h exp 1", busy_b); end
    drive(1'b1, 1'b0, 1'b1, 16'h1111, 16'hFFFF);
    checks++; if (mis_b !== 1'b0) begin errors++; $display("FAIL rearm_fill0_mis got %0h exp 0", mis_b); end
    drive(1'b1, 1'b0, 1'b1, 16'h2222, 16'hFFFF);
    checks++; if (mis_b !== 1'b0) begin errors++; $display("FAIL rearm_fill1_mis got %0h exp 0", mis_b); end
    drive(1'b1, 1'b0, 1'b1, 16'h3333, 16'h1111);
    checks++; if (mis_b !== 1'b0) begin errors++; $display("FAIL rearm_cmp0_mis got %0h exp 0", mis_b); end
    drive(1'b1, 1'b0, 1'b1, 16'h4444, 16'h0000);
    checks++; if (mis_b !== 1'b1) begin errors++; $display("FAIL rearm_cmp1_mis got %0h exp 1", mis_b); end
    checks++; if (samp_b !== 8'd1) begin errors++; $display("FAIL rearm_sample got %0h exp 1", samp_b); end
  endtask

  initial begin
    test_reset();
    test_identical();
    test_lag(2, 1'b0);
    test_lag(1, 1'b1);
    test_chan_err(1'b0);
    test_chan_err(1'b1);
    test_saturate();
    test_clear_wins();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
